// File: rtl/wishbone_fetch_master_pkg.sv
// Shared types and helpers for the Wishbone fetch master (package wb_pkg).
// The response struct is declared inside the top module because its data width is a module parameter.
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUS     = 2'd1,
        BACKOFF = 2'd2,
        RESP    = 2'd3
    } wb_master_state_t;

    // Bits needed to hold 0..value inclusive, never less than one.
    function automatic int oit_bits(input int value);
        int width;
        width = 1;
        while ((1 << width) <= value) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/wishbone_fetch_master_if.sv
// Core-side request/response port plus Wishbone master signals, grouped for the fetch master.
// Signal names keep the master's direction suffixes so both ends read the same on a waveform.
interface wishbone_fetch_master_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int SEL_WIDTH     = 4
);
    logic                     req_valid_i;
    logic                     req_ready_o;
    logic                     req_we_i;
    logic [ADDRESS_WIDTH-1:0] req_adr_i;
    logic [DATA_WIDTH-1:0]    req_dat_i;
    logic [SEL_WIDTH-1:0]     req_sel_i;

    logic                     rsp_valid_o;
    logic                     rsp_ready_i;
    logic [DATA_WIDTH-1:0]    rsp_dat_o;
    logic                     rsp_err_o;

    logic                     wb_cyc_o;
    logic                     wb_stb_o;
    logic                     wb_we_o;
    logic [ADDRESS_WIDTH-1:0] wb_adr_o;
    logic [DATA_WIDTH-1:0]    wb_dat_o;
    logic [SEL_WIDTH-1:0]     wb_sel_o;
    logic [DATA_WIDTH-1:0]    wb_dat_i;
    logic                     wb_ack_i;
    logic                     wb_err_i;
    logic                     wb_rty_i;

    modport master (
        input  req_valid_i, req_we_i, req_adr_i, req_dat_i, req_sel_i,
        output req_ready_o,
        output rsp_valid_o, rsp_dat_o, rsp_err_o,
        input  rsp_ready_i,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
    );

    modport slave (
        output req_valid_i, req_we_i, req_adr_i, req_dat_i, req_sel_i,
        input  req_ready_o,
        input  rsp_valid_o, rsp_dat_o, rsp_err_o,
        output rsp_ready_i,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
    );
endinterface

// File: rtl/wishbone_fetch_master_term_counter.sv
// Saturation-free up-counter with synchronous clear, used for the retry and watchdog counts.
module wb_term_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc) begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

    assign count = count_reg;
endmodule

// File: rtl/wishbone_fetch_master.sv
// Wishbone classic-cycle master: one outstanding single-word read/write with err/ack/rty handling.
// Define WB_FETCH_MASTER_TIMEOUT_EN to add a watchdog that aborts a cycle left unterminated.
module wishbone_fetch_master
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int SEL_WIDTH      = 4,
    parameter int MAX_RETRY      = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    wishbone_fetch_master_if.master bus
);
    localparam int RETRY_W = oit_bits(MAX_RETRY);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  err;
    } wb_rsp_t;

    if (SEL_WIDTH * 8 != DATA_WIDTH) begin : g_bad_sel
        $error("SEL_WIDTH must equal DATA_WIDTH/8");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    wb_master_state_t         state_reg, state_next;
    wb_rsp_t                  rsp_reg, rsp_next;
    logic                     we_reg;
    logic [ADDRESS_WIDTH-1:0] adr_reg;
    logic [DATA_WIDTH-1:0]    dat_reg;
    logic [SEL_WIDTH-1:0]     sel_reg;
    logic                     load_req;
    logic                     retry_inc;
    logic [RETRY_W-1:0]       retry_count;
    logic                     timeout_hit;
    logic                     any_term;

    assign any_term = bus.wb_err_i | bus.wb_ack_i | bus.wb_rty_i;

    wb_term_counter #(.WIDTH(RETRY_W)) u_retry_counter (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr     (load_req),
        .inc     (retry_inc),
        .count   (retry_count)
    );

`ifdef WB_FETCH_MASTER_TIMEOUT_EN
    localparam int TMO_W = oit_bits(TIMEOUT_CYCLES);
    logic [TMO_W-1:0] tmo_count;

    // Cleared whenever the cycle is not active, so every BUS entry (first or after BACKOFF) starts at zero.
    wb_term_counter #(.WIDTH(TMO_W)) u_timeout_counter (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr     (state_reg != BUS),
        .inc     (state_reg == BUS),
        .count   (tmo_count)
    );

    assign timeout_hit = (state_reg == BUS) && !any_term
                         && (tmo_count == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg <= IDLE;
            rsp_reg   <= '0;
            we_reg    <= 1'b0;
            adr_reg   <= '0;
            dat_reg   <= '0;
            sel_reg   <= '0;
        end else begin
            state_reg <= state_next;
            rsp_reg   <= rsp_next;
            if (load_req) begin
                we_reg  <= bus.req_we_i;
                adr_reg <= bus.req_adr_i;
                dat_reg <= bus.req_dat_i;
                sel_reg <= bus.req_sel_i;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        rsp_next   = rsp_reg;
        load_req   = 1'b0;
        retry_inc  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.req_valid_i) begin
                    load_req   = 1'b1;
                    state_next = BUS;
                end
            end
            BUS: begin
                // err beats ack beats rty when a slave raises several at once.
                if (bus.wb_err_i) begin
                    rsp_next   = '{data: '0, err: 1'b1};
                    state_next = RESP;
                end else if (bus.wb_ack_i) begin
                    rsp_next.data = we_reg ? '0 : bus.wb_dat_i;
                    rsp_next.err  = 1'b0;
                    state_next    = RESP;
                end else if (bus.wb_rty_i) begin
                    if (retry_count < RETRY_W'(MAX_RETRY)) begin
                        retry_inc  = 1'b1;
                        state_next = BACKOFF;
                    end else begin
                        rsp_next   = '{data: '0, err: 1'b1};
                        state_next = RESP;
                    end
                end else if (timeout_hit) begin
                    rsp_next   = '{data: '0, err: 1'b1};
                    state_next = RESP;
                end
            end
            BACKOFF: state_next = BUS;
            RESP: begin
                if (bus.rsp_ready_i) begin
                    rsp_next   = '0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Decoded straight from the state register so the asynchronous reset drops cyc/stb at once.
    assign bus.wb_cyc_o    = (state_reg == BUS);
    assign bus.wb_stb_o    = (state_reg == BUS);
    assign bus.wb_we_o     = we_reg;
    assign bus.wb_adr_o    = adr_reg;
    assign bus.wb_dat_o    = dat_reg;
    assign bus.wb_sel_o    = sel_reg;
    assign bus.req_ready_o = (state_reg == IDLE);
    assign bus.rsp_valid_o = (state_reg == RESP);
    assign bus.rsp_dat_o   = rsp_reg.data;
    assign bus.rsp_err_o   = rsp_reg.err;
endmodule
